// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, FSM states,
// counter width and the operation-class helpers. Optional MADD family: MDU_MADD_EN.
package mdu_pkg;

  localparam int MDU_OP_W = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Operations that occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_class(input mdu_op_e op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_class(input mdu_op_e op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request/response bundle between the datapath (master) and the MDU (slave).
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic                Start;
  logic [MDU_OP_W-1:0] MDOp;
  logic                Cancel;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                Busy;
  logic [31:0]         HI;
  logic [31:0]         LO;

  modport master (output Start, MDOp, Cancel, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDOp, Cancel, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit_md_arith.sv
// Combinational arithmetic core: produces the 64-bit {HI,LO} value an operation will commit.
// MADD/MADDU/MSUB/MSUBU results exist only when MDU_MADD_EN is defined.
module md_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o
);

  logic [63:0]        smul_s;
  logic [63:0]        umul_s;
  logic [63:0]        acc_s;
  logic [31:0]        div_b_s;
  logic signed [31:0] sq_s;
  logic signed [31:0] sr_s;
  logic [31:0]        uq_s;
  logic [31:0]        ur_s;
  logic               b_zero_s;
  logic               ovf_s;

  assign acc_s    = {hi_i, lo_i};
  assign smul_s   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign umul_s   = {32'd0, a_i} * {32'd0, b_i};
  assign b_zero_s = (b_i == 32'd0);
  assign ovf_s    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  // Divisor is forced non-zero and non-overflowing so the dividers never see the special cases.
  assign div_b_s  = (b_zero_s || ovf_s) ? 32'd1 : b_i;
  assign sq_s     = $signed(a_i) / $signed(div_b_s);
  assign sr_s     = $signed(a_i) % $signed(div_b_s);
  assign uq_s     = a_i / div_b_s;
  assign ur_s     = a_i % div_b_s;

  // Select the committed result for the requested operation.
  always_comb begin
    res_o = acc_s;
    case (op_i)
      OP_MULT:  res_o = smul_s;
      OP_MULTU: res_o = umul_s;
      OP_DIV: begin
        if (b_zero_s) begin
          res_o = {a_i, 32'hFFFF_FFFF};
        end else if (ovf_s) begin
          res_o = {32'd0, 32'h8000_0000};
        end else begin
          res_o = {sr_s, sq_s};
        end
      end
      OP_DIVU: begin
        if (b_zero_s) begin
          res_o = {a_i, 32'hFFFF_FFFF};
        end else begin
          res_o = {ur_s, uq_s};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res_o = acc_s + smul_s;
      OP_MADDU: res_o = acc_s + umul_s;
      OP_MSUB:  res_o = acc_s - smul_s;
      OP_MSUBU: res_o = acc_s - umul_s;
`endif
      default:  res_o = acc_s;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative-latency multiply/divide unit owning HI/LO; Busy drives the ID-stage stall.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (otherwise they are no-ops).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset_n,
  mult_div_unit_if.slave  mdu
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  mdu_op_e     op_s;
  logic        go_s;
  logic        mul_s;
  logic        div_s;
  logic [63:0] res_s;

  assign op_s  = mdu_op_e'(mdu.MDOp);
  assign go_s  = mdu.Start & ~mdu.Cancel & (state_q == ST_IDLE);
  assign mul_s = is_mul_class(op_s);
  assign div_s = is_div_class(op_s);

  md_arith u_arith (
    .op_i  (op_s),
    .a_i   (mdu.A),
    .b_i   (mdu.B),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (res_s)
  );

  // Busy is combinational so the very start cycle already stalls a dependent instruction in ID.
  assign mdu.Busy = (go_s & (mul_s | div_s)) | (state_q == ST_RUN);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

  // Next-state logic: launch, count down, commit pending result on the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          if (mul_s || div_s) begin
            pend_d  = res_s;
            cnt_d   = mul_s ? MUL_CNT : DIV_CNT;
            state_d = ST_RUN;
          end else if (op_s == OP_MTHI) begin
            hi_d = mdu.A;
          end else if (op_s == OP_MTLO) begin
            lo_d = mdu.A;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; a reset mid-operation drops the pending result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with a result scoreboard plus
// hand-written sequences for Start-while-busy and reset mid-operation.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset_n;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_res[$];
  int          sb_busy[$];
  int          n_vec;
  int          n_err;

  task automatic add(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic cancel, input int busy, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cancel = cancel; v.busy = busy; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Start  = 1'b0;
    bus.MDOp   = OP_NOP;
    bus.Cancel = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int          bcnt;
    logic [63:0] exp_res;
    int          exp_busy;
    bit          done;
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.MDOp   = v.op;
    bus.A      = v.a;
    bus.B      = v.b;
    bus.Cancel = v.cancel;
    sb_res.push_back({v.hi, v.lo});
    sb_busy.push_back(v.busy);
    #1;
    bcnt = bus.Busy ? 1 : 0;
    @(posedge clk);
    #1;
    idle_inputs();
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      #1;
      if (bus.Busy) bcnt++;
      else done = 1'b1;
    end
    if (!done) chk($sformatf("v%0d_busy_timeout", idx), 64'd0, 64'd1);
    exp_res  = sb_res.pop_front();
    exp_busy = sb_busy.pop_front();
    chk($sformatf("v%0d_busy_cycles", idx), 64'(bcnt), 64'(exp_busy));
    chk($sformatf("v%0d_hilo", idx), {bus.HI, bus.LO}, exp_res);
  endtask

  initial begin
    int  bcnt;
    bit  done;
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    reset_n = 1'b0;

    add(OP_MULT,  32'hFFFF_FFFD, 32'd7,        1'b0, 6,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add(OP_DIVU,  32'd100,       32'd7,        1'b0, 11, 32'd2,         32'd14);
    add(OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add(OP_DIV,   32'd5,         32'd0,        1'b0, 11, 32'd5,         32'hFFFF_FFFF);
    add(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 11, 32'd0,        32'h8000_0000);
    add(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6, 32'hFFFF_FFFE, 32'h0000_0001);
    add(OP_MULT,  32'd2,         32'd3,        1'b1, 0,  32'hFFFF_FFFE, 32'h0000_0001);
    add(OP_MTLO,  32'h1234,      32'd0,        1'b1, 0,  32'hFFFF_FFFE, 32'h0000_0001);
    add(OP_MTLO,  32'h1234,      32'd0,        1'b0, 0,  32'hFFFF_FFFE, 32'h0000_1234);
    add(OP_MTHI,  32'hCAFE,      32'd0,        1'b0, 0,  32'h0000_CAFE, 32'h0000_1234);
    add(OP_MFHI,  32'd9,         32'd9,        1'b0, 0,  32'h0000_CAFE, 32'h0000_1234);
    add(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, 11, 32'd1,        32'hFFFF_FFFD);
    add(OP_DIVU,  32'hFFFF_FFFF, 32'd0,        1'b0, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, 6, 32'h4000_0000, 32'd0);
    add(OP_MTHI,  32'd0,         32'd0,        1'b0, 0,  32'd0,         32'd0);
    add(OP_MTLO,  32'hFFFF_FFFF, 32'd0,        1'b0, 0,  32'd0,         32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    add(OP_MADDU, 32'd1,         32'd1,        1'b0, 6,  32'd1,         32'd0);
`else
    add(OP_MADDU, 32'd1,         32'd1,        1'b0, 0,  32'd0,         32'hFFFF_FFFF);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Start MULT arriving while a DIV runs must be ignored.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
    #1;
    bcnt = bus.Busy ? 1 : 0;
    done = 1'b0;
    for (int c = 1; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.Start = 1'b1; bus.MDOp = OP_MULT; bus.A = 32'd2; bus.B = 32'd3;
      end else begin
        idle_inputs();
      end
      #1;
      if (bus.Busy) bcnt++;
      else done = 1'b1;
    end
    idle_inputs();
    if (!done) chk("busy_start_timeout", 64'd0, 64'd1);
    chk("busy_start_cycles", 64'(bcnt), 64'd11);
    chk("busy_start_hilo", {bus.HI, bus.LO}, {32'd2, 32'd14});

    // Reset in cycle 4 of a DIV aborts it with no late commit.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = OP_DIV; bus.A = 32'd50; bus.B = 32'd3;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_hilo", {bus.HI, bus.LO}, 64'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("midrst_no_commit", {bus.HI, bus.LO}, 64'd0);
    chk("midrst_busy_late", 64'(bus.Busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
